// File: rtl/qpp_addr_gen_pkg.sv
// Shared constants for the QPP interleaver address generator: block sizes,
// permutation polynomial coefficients, derived increments and FSM encoding.
package qpp_addr_gen_pkg;

    localparam int unsigned AW = 13;   // address / index width
    localparam int unsigned SW = 14;   // width of an unreduced modular sum

    // Block size select 0
    localparam logic [AW-1:0] K_SMALL    = 13'd1056;
    localparam logic [AW-1:0] F1_SMALL   = 13'd17;
    localparam logic [AW-1:0] F2_SMALL   = 13'd66;
    localparam logic [AW-1:0] STEP_SMALL = 13'(2 * F2_SMALL);
    localparam logic [AW-1:0] G0_SMALL   = 13'((F1_SMALL + F2_SMALL) % K_SMALL);

    // Block size select 1
    localparam logic [AW-1:0] K_LARGE    = 13'd6144;
    localparam logic [AW-1:0] F1_LARGE   = 13'd263;
    localparam logic [AW-1:0] F2_LARGE   = 13'd480;
    localparam logic [AW-1:0] STEP_LARGE = 13'(2 * F2_LARGE);
    localparam logic [AW-1:0] G0_LARGE   = 13'((F1_LARGE + F2_LARGE) % K_LARGE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [AW-1:0] k_size(input logic sel);
        return sel ? K_LARGE : K_SMALL;
    endfunction

    function automatic logic [AW-1:0] g_init(input logic sel);
        return sel ? G0_LARGE : G0_SMALL;
    endfunction

    function automatic logic [AW-1:0] g_step(input logic sel);
        return sel ? STEP_LARGE : STEP_SMALL;
    endfunction

endpackage

// File: rtl/qpp_addr_gen_mod_add.sv
// Single-step modular adder: both operands must already be below mod_i, so
// one conditional subtraction fully reduces the sum.
module mod_add
    import qpp_addr_gen_pkg::*;
(
    input  logic [AW-1:0] a_i,
    input  logic [AW-1:0] b_i,
    input  logic [AW-1:0] mod_i,
    output logic [AW-1:0] sum_o
);

    logic [SW-1:0] raw_sum;
    logic [SW-1:0] red_sum;

    // Add with a carry bit, then subtract the modulus once if it overflowed K
    always_comb begin
        raw_sum = {1'b0, a_i} + {1'b0, b_i};
        red_sum = raw_sum - {1'b0, mod_i};
        if (raw_sum >= {1'b0, mod_i}) begin
            sum_o = red_sum[AW-1:0];
        end else begin
            sum_o = raw_sum[AW-1:0];
        end
    end

endmodule

// File: rtl/qpp_addr_gen.sv
// QPP interleaver address generator. Produces pi(i) = (f1*i + f2*i^2) mod K
// for i = 0..K-1 using two running modular sums instead of multipliers,
// with a valid/ready handshake toward the consumer.
//
// state | meaning
// IDLE  | waiting for start; outputs idle
// RUN   | presenting (idx, addr) pairs, advancing on each transfer
// DONE  | one-cycle done pulse after the final transfer
module qpp_addr_gen
    import qpp_addr_gen_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          k,
    input  logic          addr_ready,
    output logic [AW-1:0] addr,
    output logic [AW-1:0] idx,
    output logic          addr_valid,
    output logic          last,
    output logic          busy,
    output logic          done,
    output logic          k_latched
);

    state_e        state_q, state_d;
    logic [AW-1:0] pi_q, pi_d;
    logic [AW-1:0] g_q, g_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          kl_q, kl_d;

    logic [AW-1:0] k_mod;
    logic [AW-1:0] idx_max;
    logic [AW-1:0] step;
    logic [AW-1:0] pi_next;
    logic [AW-1:0] g_next;

    assign k_mod   = k_size(kl_q);
    assign idx_max = k_mod - 13'd1;
    assign step    = g_step(kl_q);

    mod_add u_pi_add (
        .a_i   (pi_q),
        .b_i   (g_q),
        .mod_i (k_mod),
        .sum_o (pi_next)
    );

    mod_add u_g_add (
        .a_i   (g_q),
        .b_i   (step),
        .mod_i (k_mod),
        .sum_o (g_next)
    );

    // Next-state logic: load on acceptance, advance only on a transfer
    always_comb begin
        state_d = state_q;
        pi_d    = pi_q;
        g_d     = g_q;
        idx_d   = idx_q;
        kl_d    = kl_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    kl_d    = k;
                    pi_d    = '0;
                    idx_d   = '0;
                    g_d     = g_init(k);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (addr_ready) begin
                    if (idx_q == idx_max) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 13'd1;
                        pi_d  = pi_next;
                        g_d   = g_next;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pi_q    <= '0;
            g_q     <= '0;
            idx_q   <= '0;
            kl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pi_q    <= pi_d;
            g_q     <= g_d;
            idx_q   <= idx_d;
            kl_q    <= kl_d;
        end
    end

    assign addr       = pi_q;
    assign idx        = idx_q;
    assign addr_valid = (state_q == ST_RUN);
    assign last       = (state_q == ST_RUN) && (idx_q == idx_max);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign k_latched  = kl_q;

endmodule

// File: tb/tb_qpp_addr_gen.sv
module tb_qpp_addr_gen;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        k;
    logic        addr_ready;
    logic [12:0] addr;
    logic [12:0] idx;
    logic        addr_valid;
    logic        last;
    logic        busy;
    logic        done;
    logic        k_latched;

    typedef struct packed {
        logic [12:0] a;
        logic [12:0] i;
        logic        l;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [12:0] first_addr[4];
    logic [12:0] last_addr;
    int          n_xfer;
    bit          seen[6144];

    always #5 clock = ~clock;

    qpp_addr_gen dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .k          (k),
        .addr_ready (addr_ready),
        .addr       (addr),
        .idx        (idx),
        .addr_valid (addr_valid),
        .last       (last),
        .busy       (busy),
        .done       (done),
        .k_latched  (k_latched)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Closed-form reference, independent of the incremental hardware method
    function automatic int pi_ref(input int i, input bit ks);
        longint kk = ks ? 6144 : 1056;
        longint f1 = ks ? 263 : 17;
        longint f2 = ks ? 480 : 66;
        longint ii = i;
        return int'((f1 * ii + f2 * ii * ii) % kk);
    endfunction

    // One block: start, consume every address, check done pulse.
    // stall: random addr_ready; noise: random start/k during RUN;
    // hold: keep start high throughout; abort_at: reset when idx reaches it.
    task automatic run_block(input bit ks, input bit stall, input bit noise,
                             input bit hold, input int abort_at);
        int          kk;
        int          budget;
        int          cnt;
        bit          stalled;
        bit          fin;
        logic [12:0] p_addr;
        logic [12:0] p_idx;
        exp_t        e;

        kk      = ks ? 6144 : 1056;
        stalled = 0;
        fin     = 0;
        p_addr  = '0;
        p_idx   = '0;
        sb_q.delete();
        for (int i = 0; i < kk; i++) begin
            e.a = 13'(pi_ref(i, ks));
            e.i = 13'(i);
            e.l = (i == kk - 1);
            sb_q.push_back(e);
        end
        foreach (seen[j]) seen[j] = 0;
        n_xfer = 0;

        start      = 1'b1;
        k          = ks;
        addr_ready = 1'b1;
        @(negedge clock);
        start = hold;
        check_eq("first_valid_latency", addr_valid, 1);
        check_eq("k_latched_at_start", k_latched, ks);
        check_eq("busy_in_run", busy, 1);

        budget = 8 * kk + 50;
        while (!fin) begin
            if (budget == 0) begin
                check_eq("timeout_xfers", n_xfer, kk);
                sb_q.delete();
                break;
            end
            budget--;

            check_eq("valid_in_run", addr_valid, 1);
            check_eq("no_early_done", done, 0);
            if (noise) check_eq("k_latched_hold", k_latched, ks);
            if (stalled) begin
                check_eq("stall_addr", addr, p_addr);
                check_eq("stall_idx", idx, p_idx);
            end

            if (abort_at >= 0 && int'(idx) == abort_at) begin
                reset_n = 1'b0;
                start   = 1'b1;
                @(negedge clock);
                check_eq("abort_valid", addr_valid, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_done", done, 0);
                check_eq("abort_addr", addr, 0);
                check_eq("abort_idx", idx, 0);
                check_eq("abort_k_latched", k_latched, 0);
                reset_n = 1'b1;
                start   = 1'b0;
                @(negedge clock);
                check_eq("abort_no_done", done, 0);
                check_eq("abort_idle", addr_valid, 0);
                sb_q.delete();
                return;
            end

            addr_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (addr_ready) begin
                e = sb_q.pop_front();
                check_eq("addr", addr, e.a);
                check_eq("idx", idx, e.i);
                check_eq("last", last, e.l);
                if (idx < 4) first_addr[idx[1:0]] = addr;
                if (last) last_addr = addr;
                if (addr < 6144) begin
                    if (seen[addr]) check_eq("addr_duplicate", addr, 13'h1fff);
                    seen[addr] = 1;
                end
                n_xfer++;
                stalled = 0;
                if (sb_q.size() == 0) fin = 1;
            end else begin
                stalled = 1;
                p_addr  = addr;
                p_idx   = idx;
            end

            if (noise) begin
                if (sb_q.size() > 4) begin
                    start = 1'($urandom_range(0, 1));
                    k     = 1'($urandom_range(0, 1));
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clock);
        end

        check_eq("done_pulse", done, 1);
        check_eq("valid_off_in_done", addr_valid, 0);
        check_eq("busy_in_done", busy, 1);
        @(negedge clock);
        check_eq("done_one_cycle", done, 0);
        check_eq("busy_idle", busy, 0);
        check_eq("valid_idle", addr_valid, 0);
        check_eq("transfer_count", n_xfer, kk);
        cnt = 0;
        foreach (seen[j]) if (seen[j]) cnt++;
        check_eq("permutation_cover", cnt, kk);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        k          = 1'b0;
        addr_ready = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_addr", addr, 0);
        check_eq("rst_idx", idx, 0);
        check_eq("rst_valid", addr_valid, 0);
        check_eq("rst_last", last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_k_latched", k_latched, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("idle_no_valid", addr_valid, 0);

        // k=0 full-rate
        run_block(0, 0, 0, 0, -1);
        check_eq("k0_addr0", first_addr[0], 0);
        check_eq("k0_addr1", first_addr[1], 83);
        check_eq("k0_addr2", first_addr[2], 298);
        check_eq("k0_addr3", first_addr[3], 645);
        check_eq("k0_last_addr", last_addr, 49);

        // k=1 full-rate, permutation check inside
        run_block(1, 0, 0, 0, -1);
        check_eq("k1_addr0", first_addr[0], 0);
        check_eq("k1_addr1", first_addr[1], 743);
        check_eq("k1_addr2", first_addr[2], 2446);
        check_eq("k1_last_addr", last_addr, 217);

        // k=0 with random stalls
        run_block(0, 1, 0, 0, -1);

        // reset mid-block, then restart
        run_block(1, 0, 0, 0, 500);
        run_block(0, 0, 0, 0, -1);

        // start and k noise during RUN
        run_block(0, 0, 1, 0, -1);

        // start held through DONE: next block starts from IDLE
        run_block(0, 0, 0, 1, -1);
        check_eq("hold_idle_start_seen", start, 1);
        run_block(0, 0, 0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/qpp_addr_gen.md
QPP_ADDR_GEN -- requirements
Module: qpp_addr_gen

Interface
REQ-001 SHALL have no parameters; all constants come from the shared package.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising clock.
REQ-004 start  input  1  request for a new block; accepted only in IDLE.
REQ-005 k  input  1  block size select: 0 = K 1056, 1 = K 6144; sampled on start acceptance.
REQ-006 addr_ready  input  1  consumer ready; an address transfers when addr_valid && addr_ready.
REQ-007 addr  output  13  interleaved read address pi(i), range 0..K-1.
REQ-008 idx  output  13  sequential index i paired with addr.
REQ-009 addr_valid  output  1  addr/idx hold a valid pair.
REQ-010 last  output  1  high with the valid pair where i = K-1.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 done  output  1  one-cycle pulse after the last transfer.
REQ-013 k_latched  output  1  k captured at start acceptance, held until the next acceptance.

Function
REQ-014 SHALL generate pi(i) = (f1*i + f2*i^2) mod K: K 1056 uses f1 17, f2 66; K 6144 uses f1 263, f2 480.
REQ-015 SHALL compute pi incrementally with no multiplier: pi(0) = 0, g(0) = (f1+f2) mod K, pi(i+1) = (pi(i)+g(i)) mod K, g(i+1) = (g(i)+2*f2) mod K.
REQ-016 SHALL perform each modular add as a 14-bit sum, subtracting K once when sum >= K; no iterative reduction.
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE: addr_valid 0; on start, latch k, load pi 0, idx 0, g(0), then go to RUN.
REQ-019 RUN: addr_valid 1 from the cycle after acceptance, so latency start -> first valid is 1 clock.
REQ-020 RUN: on a transfer with idx < K-1, advance idx, pi and g in the same cycle, so back-to-back transfers yield one address per clock.
REQ-021 RUN: when addr_ready is 0, addr, idx and last SHALL stay stable and g SHALL NOT advance.
REQ-022 RUN: on the transfer with idx = K-1, go to DONE; addr_valid deasserts next cycle.
REQ-023 DONE: assert done for exactly one cycle, then return to IDLE.
REQ-024 start SHALL be ignored in RUN and DONE; k changes after acceptance SHALL have no effect.
REQ-025 start in the same cycle the FSM enters IDLE from DONE SHALL be accepted on the following cycle only if still asserted.

Reset
REQ-026 reset_n low SHALL force IDLE with addr 0, idx 0, g 0, addr_valid 0, last 0, busy 0, done 0, k_latched 0.
REQ-027 Reset asserted mid-RUN SHALL abort the block with no done pulse, and reset SHALL dominate start.

Structure
REQ-028 The shared package SHALL hold: the K values 1056 and 6144, the f1/f2 pairs, the 2*f2 steps, (f1+f2) mod K, the 13-bit address width, and the FSM state encoding.
REQ-029 The modular-add-with-conditional-subtract SHALL be one sub-module, mod_add, instantiated twice (pi update and g update).

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- k=0, start, addr_ready=1: first four addrs 0, 83, 298, 645; idx=1055 gives addr 49 with last=1; done 1 cycle later; 1056 transfers total.
- k=1, start, addr_ready=1: first addrs 0, 743, 2446; idx=6143 gives addr 217 with last=1; full output is a permutation of 0..6143 (scoreboard bitmap).
- k=0 with random addr_ready stalls: sequence identical to the no-stall run; addr and idx stable while stalled.
- reset_n low at idx=500 (k=1): next cycle addr_valid=0, busy=0, no done; a new start restarts at addr 0.
- start pulsed repeatedly during RUN and k toggled: no restart; k_latched unchanged; one done per block.
- start held high through DONE: the next block starts after the return to IDLE, with first valid addr 0.
